// File: rtl/game_pkg.sv
// Shared timing constants for the game tick dividers (100 MHz system clock).
package game_pkg;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned HALF_250MS = 12_500_000;
  localparam int unsigned HALF_500MS = 25_000_000;
  localparam int unsigned HALF_5S    = 250_000_000;
  localparam int unsigned CNT_W      = 28;

endpackage : game_pkg

// File: rtl/sq_divider.sv
// Free-running square-wave divider: toggles every HALF cycles and emits a
// one-cycle tick in the first cycle the square wave is high.
module sq_divider #(
  parameter int unsigned HALF  = 1,
  parameter int unsigned CNT_W = 28
) (
  input  logic clk_100mhz,
  input  logic rst,
  output logic sq,
  output logic tick
);

  localparam longint unsigned HALF_MAX = 64'(1) << CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  if (HALF == 0 || 64'(HALF) > HALF_MAX) begin : g_half_range
    $fatal(1, "sq_divider: HALF=%0d outside 1..2**%0d", HALF, CNT_W);
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_sq;
  logic             r_tick;

  // Reload at HALF-1; the tick is the new square-wave value only on a 0->1 toggle.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_sq   <= ~r_sq;
      r_tick <= ~r_sq;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign sq   = r_sq;
  assign tick = r_tick;

endmodule : sq_divider

// File: rtl/game_tick_divider.sv
// Derives the 250 ms / 500 ms / 5 s game-timing square waves and rise ticks
// from the 100 MHz system clock; the three channels run independently.
module game_tick_divider #(
  parameter int unsigned HALF_250MS = game_pkg::HALF_250MS,
  parameter int unsigned HALF_500MS = game_pkg::HALF_500MS,
  parameter int unsigned HALF_5S    = game_pkg::HALF_5S,
  parameter int unsigned CNT_W      = game_pkg::CNT_W
) (
  input  logic clk_100mhz,
  input  logic rst,
  output logic clk_250ms,
  output logic clk_500ms,
  output logic clk_5s,
  output logic tick_250ms,
  output logic tick_500ms,
  output logic tick_5s
);

  sq_divider #(.HALF(HALF_250MS), .CNT_W(CNT_W)) u_div_250ms (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .sq         (clk_250ms),
    .tick       (tick_250ms)
  );

  sq_divider #(.HALF(HALF_500MS), .CNT_W(CNT_W)) u_div_500ms (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .sq         (clk_500ms),
    .tick       (tick_500ms)
  );

  sq_divider #(.HALF(HALF_5S), .CNT_W(CNT_W)) u_div_5s (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .sq         (clk_5s),
    .tick       (tick_5s)
  );

endmodule : game_tick_divider

// File: tb/tb_game_tick_divider.sv
// Bench for game_tick_divider: shortened half-periods plus a degenerate
// HALF_250MS=1 instance, checked every cycle against an edge-count model.
module tb_game_tick_divider;

  localparam int unsigned H_A = 5;
  localparam int unsigned H_B = 10;
  localparam int unsigned H_C = 100;
  localparam int unsigned NCH = 6;

  // Channels 0..2 belong to dut, 3..5 to dut1 (HALF_250MS = 1).
  int unsigned half_of [NCH] = '{H_A, H_B, H_C, 1, H_B, H_C};
  string       name_of [NCH] = '{"a250", "a500", "a5s", "b250", "b500", "b5s"};

  logic           clk_100mhz = 1'b0;
  logic           rst        = 1'b1;
  logic [NCH-1:0] sq_v;
  logic [NCH-1:0] tk_v;

  int unsigned    n;
  int unsigned    cyc;
  int unsigned    last_rise [NCH];
  bit             rise_ok   [NCH];
  int unsigned    tick_cnt  [NCH];
  int unsigned    high_cnt  [NCH];
  logic [NCH-1:0] prev_sq;
  int             n_cmp = 0;
  int             n_err = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  game_tick_divider #(.HALF_250MS(H_A), .HALF_500MS(H_B), .HALF_5S(H_C), .CNT_W(28)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clk_250ms  (sq_v[0]),
    .clk_500ms  (sq_v[1]),
    .clk_5s     (sq_v[2]),
    .tick_250ms (tk_v[0]),
    .tick_500ms (tk_v[1]),
    .tick_5s    (tk_v[2])
  );

  game_tick_divider #(.HALF_250MS(1), .HALF_500MS(H_B), .HALF_5S(H_C), .CNT_W(28)) dut1 (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clk_250ms  (sq_v[3]),
    .clk_500ms  (sq_v[4]),
    .clk_5s     (sq_v[5]),
    .tick_250ms (tk_v[3]),
    .tick_500ms (tk_v[4]),
    .tick_5s    (tk_v[5])
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d, edge %0d)", tag, obs, want, cyc, n);
    end
  endtask

  // Square wave after e edges since release: high during odd-numbered half periods.
  function automatic bit want_sq(int unsigned e, int unsigned h);
    return ((e / h) % 2) == 1;
  endfunction

  // Tick is high right after edges h, 3h, 5h, ...
  function automatic bit want_tick(int unsigned e, int unsigned h);
    return (e % (2 * h)) == h;
  endfunction

  task automatic clear_win();
    for (int k = 0; k < NCH; k++) begin
      tick_cnt[k] = 0;
      high_cnt[k] = 0;
    end
  endtask

  // One clock: advance the model edge count, then check every channel.
  task automatic step();
    @(posedge clk_100mhz);
    #1;
    cyc++;
    if (rst) n = 0;
    else     n++;
    for (int k = 0; k < NCH; k++) begin
      chk_eq({name_of[k], "_sq"},   32'(sq_v[k]), 32'(want_sq(n, half_of[k])));
      chk_eq({name_of[k], "_tick"}, 32'(tk_v[k]), 32'(want_tick(n, half_of[k])));
      if (rst) begin
        rise_ok[k] = 1'b0;
      end else if (sq_v[k] && !prev_sq[k]) begin
        if (rise_ok[k]) chk_eq({name_of[k], "_period"}, cyc - last_rise[k], 2 * half_of[k]);
        last_rise[k] = cyc;
        rise_ok[k]   = 1'b1;
      end
      if (sq_v[k]) high_cnt[k]++;
      if (tk_v[k]) tick_cnt[k]++;
    end
    prev_sq = sq_v;
  endtask

  initial begin
    n       = 0;
    cyc     = 0;
    prev_sq = '0;
    for (int k = 0; k < NCH; k++) begin
      last_rise[k] = 0;
      rise_ok[k]   = 1'b0;
    end
    clear_win();

    rst = 1'b1;
    repeat (3) step();
    chk_eq("reset_all_zero", 32'({sq_v, tk_v}), 0);

    rst = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      step();
      if (n == H_A) begin
        chk_eq("first_rise_250", 32'(sq_v[0]), 1);
        chk_eq("first_tick_250", 32'(tk_v[0]), 1);
      end
      if (n == H_A + 1)   chk_eq("tick_250_single", 32'(tk_v[0]), 0);
      if (n == 2 * H_A)   chk_eq("first_fall_250", 32'(sq_v[0]), 0);
    end

    // Reset sampled at edge 57, mid-period on every channel.
    rst = 1'b1;
    step();
    chk_eq("mid_rst_all_zero", 32'({sq_v, tk_v}), 0);
    rst = 1'b0;

    clear_win();
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (n == H_A - 1) chk_eq("no_rise_before_5", 32'(sq_v[0]), 0);
      if (n == H_A)     chk_eq("rise_5_after_rel", 32'(sq_v[0]), 1);
      if (n == 99)      chk_eq("pre_coincide",     32'(sq_v[2:0]), 32'(3'b011));
      if (n == 100)     chk_eq("coincide_100",     32'(sq_v[2:0]), 32'(3'b100));
    end
    for (int k = 0; k < NCH; k++) begin
      chk_eq({name_of[k], "_tick_count"}, tick_cnt[k], 1000 / (2 * half_of[k]));
      chk_eq({name_of[k], "_high_count"}, high_cnt[k], 500);
    end

    // Random reset pulses on top of free running.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_game_tick_divider
